// File: rtl/adda_mc_pipe.sv
// ---------------------------------------------------------------------------
// adda_mc_pipe
//
// Pipelined, multi-channel log-domain adder. For each accepted sample it
// computes DQL = DQLN + (Y >> Y_SHIFT), tags it with its channel, and flags
// signed positive overflow. The result is either wrapped (bit-exact with the
// scalar adder) or clamped to the largest positive value. Overflow events are
// counted per channel, and the controller can read the counters back.
//
// Pipeline: stage 1 holds sum/flag/tag, stage 2 is the output register.
// Latency is 2 cycles from input accept to output valid. Throughput is one
// sample per clock. Back-pressure is valid/ready at both ends.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   IN_VALID   input sample valid
//   IN_READY   block accepts a sample this cycle (combinational)
//   CH_IN      channel tag of the input sample
//   DQLN       log of the normalized quantized difference (two's complement)
//   Y          quantizer scale factor (unsigned)
//   OUT_VALID  output sample valid
//   OUT_READY  downstream accepts the output sample
//   CH_OUT     channel tag of the output sample
//   DQL        log of the quantized difference
//   OVF        output sample overflowed (wrapped or clamped)
//   CNT_CLR    synchronous clear of all overflow counters
//   CNT_SEL    overflow counter read select
//   CNT_OUT    registered overflow count of channel CNT_SEL
// ---------------------------------------------------------------------------
module adda_mc_pipe #(
   parameter int DQL_W   = 12,
   parameter int Y_W     = 13,
   parameter int Y_SHIFT = 2,
   parameter int NCH     = 32,
   parameter int SAT_EN  = 0,
   parameter int CNT_W   = 16,
   parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [CH_W-1:0]  CH_IN,
   input  logic [DQL_W-1:0] DQLN,
   input  logic [Y_W-1:0]   Y,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [CH_W-1:0]  CH_OUT,
   output logic [DQL_W-1:0] DQL,
   output logic             OVF,
   input  logic             CNT_CLR,
   input  logic [CH_W-1:0]  CNT_SEL,
   output logic [CNT_W-1:0] CNT_OUT
);

   localparam int B_W = Y_W - Y_SHIFT;
   localparam logic [DQL_W-1:0] SAT_MAX = {1'b0, {(DQL_W-1){1'b1}}};

   // Pipeline registers
   logic             s1Valid_q;
   logic [DQL_W-1:0] s1Dql_q;
   logic             s1Ovf_q;
   logic [CH_W-1:0]  s1Ch_q;

   logic             outValid_q;
   logic [DQL_W-1:0] outDql_q;
   logic             outOvf_q;
   logic [CH_W-1:0]  outCh_q;

   // Overflow counters and registered read port
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];
   logic [CNT_W-1:0] cntOut_q;
   logic [CNT_W-1:0] cntOut_d;

   // Datapath / handshake nets
   logic [DQL_W-1:0] addB;
   logic [DQL_W-1:0] sum;
   logic             ovfRaw;
   logic [DQL_W-1:0] s1Dql_d;
   logic             adv1;
   logic             adv2;
   logic             countEvent;

   // The bits of Y that are shifted out do not take part in the sum.
   generate
      if (Y_SHIFT > 0) begin : gLowY
         logic unusedYLow;
         assign unusedYLow = ^Y[Y_SHIFT-1:0];
      end
   endgenerate

   // Stage 2 advances when it is empty or being drained. Stage 1 advances
   // when it is empty or can move into stage 2. An input is accepted whenever
   // stage 1 can advance, so a full pipeline under back-pressure stalls the
   // input without dropping anything.
   assign adv2     = !outValid_q || OUT_READY;
   assign adv1     = !s1Valid_q || adv2;
   assign IN_READY = adv1;

   // The shifted scale factor is zero-extended, so it is never negative.
   // Because of that, the sum can only overflow upward, and only from a
   // non-negative DQLN. A carry-out with a negative DQLN is an ordinary
   // wrap back toward zero and is not an overflow.
   assign addB    = {{(DQL_W-B_W){1'b0}}, Y[Y_W-1:Y_SHIFT]};
   assign sum     = DQLN + addB;
   assign ovfRaw  = !DQLN[DQL_W-1] && sum[DQL_W-1];
   assign s1Dql_d = ((SAT_EN != 0) && ovfRaw) ? SAT_MAX : sum;

   // Stage 1 captures the arithmetic result, overflow flag and tag for
   // every accepted sample. When no sample arrives it simply goes empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1Valid_q <= 1'b0;
         s1Dql_q   <= '0;
         s1Ovf_q   <= 1'b0;
         s1Ch_q    <= '0;
      end else if (adv1) begin
         s1Valid_q <= IN_VALID;
         if (IN_VALID) begin
            s1Dql_q <= s1Dql_d;
            s1Ovf_q <= ovfRaw;
            s1Ch_q  <= CH_IN;
         end
      end
   end

   // Stage 2 is the output register. It only reloads when it can advance,
   // so a stalled output keeps DQL/CH_OUT/OVF stable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outValid_q <= 1'b0;
         outDql_q   <= '0;
         outOvf_q   <= 1'b0;
         outCh_q    <= '0;
      end else if (adv2) begin
         outValid_q <= s1Valid_q;
         if (s1Valid_q) begin
            outDql_q <= s1Dql_q;
            outOvf_q <= s1Ovf_q;
            outCh_q  <= s1Ch_q;
         end
      end
   end

   assign OUT_VALID = outValid_q;
   assign DQL       = outDql_q;
   assign OVF       = outOvf_q;
   assign CH_OUT    = outCh_q;

   // A counter is charged when an overflowing sample moves from stage 1
   // into stage 2. That happens exactly once per sample, however long the
   // output stalls.
   assign countEvent = s1Valid_q && s1Ovf_q && adv2;

   // Counter next state. A clear overrides any same-cycle increment.
   // Counters stick at their maximum. Tags outside 0..NCH-1 match no
   // counter, so those samples pass through without being counted.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         cnt_d[c] = cnt_q[c];
      end
      if (CNT_CLR) begin
         for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = '0;
         end
      end else if (countEvent) begin
         for (int c = 0; c < NCH; c++) begin
            if ((s1Ch_q == CH_W'(c)) && (cnt_q[c] != {CNT_W{1'b1}})) begin
               cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
         end
      end
   end

   // Read mux for the controller. An out-of-range select reads zero.
   always_comb begin
      cntOut_d = '0;
      for (int c = 0; c < NCH; c++) begin
         if (CNT_SEL == CH_W'(c)) begin
            cntOut_d = cnt_q[c];
         end
      end
   end

   // Counter bank and the registered read port. CNT_OUT shows the value
   // the selected counter held before this edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NCH; c++) begin
            cnt_q[c] <= '0;
         end
         cntOut_q <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
         cntOut_q <= cntOut_d;
      end
   end

   assign CNT_OUT = cntOut_q;

endmodule

// File: tb/tb_adda_mc_pipe.sv
// ---------------------------------------------------------------------------
// tb_adda_mc_pipe
//
// Directed bench for adda_mc_pipe. Two instances share the same stimulus:
// one wraps on overflow, the other saturates. The bench covers:
//   - reset values
//   - single-sample latency
//   - a table of arithmetic vectors, including the overflow and carry-out
//     boundaries
//   - a back-pressured stream
//   - per-channel overflow counters, including clear-versus-increment
//   - asynchronous reset with samples still in flight
// ---------------------------------------------------------------------------
module tb_adda_mc_pipe;

   localparam int CH_W = 5;

   logic        clk = 1'b0;
   logic        resetN;
   logic        inValid;
   logic [CH_W-1:0] chIn;
   logic [11:0] dqln;
   logic [12:0] y;
   logic        outReady;
   logic        cntClr;
   logic [CH_W-1:0] cntSel;

   logic        inReady0, outValid0, ovf0;
   logic [CH_W-1:0] chOut0;
   logic [11:0] dql0;
   logic [15:0] cntOut0;

   logic        inReady1, outValid1, ovf1;
   logic [CH_W-1:0] chOut1;
   logic [11:0] dql1;
   logic [15:0] cntOut1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [11:0] dqln;
      logic [12:0] y;
      logic [4:0]  ch;
      logic [11:0] expWrap;
      logic        expOvf;
      logic [11:0] expSat;
   } vecT;

   vecT vecs[9];

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Wrapping instance (legacy bit-exact behaviour)
   adda_mc_pipe #(.SAT_EN(0)) dutWrap (
      .clk(clk), .reset_n(resetN),
      .IN_VALID(inValid), .IN_READY(inReady0), .CH_IN(chIn), .DQLN(dqln), .Y(y),
      .OUT_VALID(outValid0), .OUT_READY(outReady), .CH_OUT(chOut0), .DQL(dql0), .OVF(ovf0),
      .CNT_CLR(cntClr), .CNT_SEL(cntSel), .CNT_OUT(cntOut0)
   );

   // Saturating instance
   adda_mc_pipe #(.SAT_EN(1)) dutSat (
      .clk(clk), .reset_n(resetN),
      .IN_VALID(inValid), .IN_READY(inReady1), .CH_IN(chIn), .DQLN(dqln), .Y(y),
      .OUT_VALID(outValid1), .OUT_READY(outReady), .CH_OUT(chOut1), .DQL(dql1), .OVF(ovf1),
      .CNT_CLR(cntClr), .CNT_SEL(cntSel), .CNT_OUT(cntOut1)
   );

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [11:0] d, input logic [12:0] yy, input logic [4:0] ch);
      inValid = v;
      dqln    = d;
      y       = yy;
      chIn    = ch;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic readCounter(input logic [4:0] sel, input string name, input logic [15:0] expected);
      cntSel = sel;
      tick();
      checkOutput({name, " wrap"}, cntOut0, expected);
      checkOutput({name, " sat"}, cntOut1, expected);
   endtask

   int sent, recv, doneCycle, readyLow;
   logic stallPrev, takeOut, takeIn;
   logic [11:0] heldDql;

   initial begin
      // Vector table: inputs and hand-computed wrap/sat results
      vecs[0] = '{12'h100, 13'h0400, 5'd0, 12'h200, 1'b0, 12'h200};
      vecs[1] = '{12'h7F0, 13'h1FFC, 5'd1, 12'hFEF, 1'b1, 12'h7FF};
      vecs[2] = '{12'hF00, 13'h0400, 5'd5, 12'h000, 1'b0, 12'h000};
      vecs[3] = '{12'h000, 13'h0003, 5'd2, 12'h000, 1'b0, 12'h000};
      vecs[4] = '{12'h7FF, 13'h0004, 5'd1, 12'h800, 1'b1, 12'h7FF};
      vecs[5] = '{12'h800, 13'h1FFF, 5'd6, 12'hFFF, 1'b0, 12'hFFF};
      vecs[6] = '{12'h3FF, 13'h1000, 5'd0, 12'h7FF, 1'b0, 12'h7FF};
      vecs[7] = '{12'h400, 13'h1000, 5'd2, 12'h800, 1'b1, 12'h7FF};
      vecs[8] = '{12'hFFF, 13'h0007, 5'd5, 12'h000, 1'b0, 12'h000};

      resetN   = 1'b0;
      outReady = 1'b1;
      cntClr   = 1'b0;
      cntSel   = '0;
      applyStimulus(1'b0, 12'h0, 13'h0, 5'd0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset OUT_VALID", outValid0, 0);
      checkOutput("reset DQL", dql0, 0);
      checkOutput("reset CH_OUT", chOut0, 0);
      checkOutput("reset OVF", ovf0, 0);
      checkOutput("reset CNT_OUT", cntOut0, 0);
      checkOutput("reset IN_READY", inReady0, 1);
      @(negedge clk);
      resetN = 1'b1;
      tick();

      // T1: output valid exactly two clocks after accept
      applyStimulus(1'b1, 12'h100, 13'h0400, 5'd0);
      tick();
      checkOutput("T1 valid after 1 clk", outValid0, 0);
      applyStimulus(1'b0, 12'h0, 13'h0, 5'd0);
      tick();
      checkOutput("T1 valid after 2 clk", outValid0, 1);
      checkOutput("T1 DQL", dql0, 12'h200);
      checkOutput("T1 OVF", ovf0, 0);
      tick();

      // Table-driven arithmetic: result of vector i-1 appears after edge i
      for (int i = 0; i <= 9; i++) begin
         if (i < 9) applyStimulus(1'b1, vecs[i].dqln, vecs[i].y, vecs[i].ch);
         else       applyStimulus(1'b0, 12'h0, 13'h0, 5'd0);
         tick();
         if (i >= 1) begin
            checkOutput($sformatf("vec%0d valid", i-1), outValid0, 1);
            checkOutput($sformatf("vec%0d DQL wrap", i-1), dql0, vecs[i-1].expWrap);
            checkOutput($sformatf("vec%0d OVF wrap", i-1), ovf0, vecs[i-1].expOvf);
            checkOutput($sformatf("vec%0d CH_OUT", i-1), chOut0, vecs[i-1].ch);
            checkOutput($sformatf("vec%0d DQL sat", i-1), dql1, vecs[i-1].expSat);
            checkOutput($sformatf("vec%0d OVF sat", i-1), ovf1, vecs[i-1].expOvf);
         end
      end
      tick();
      checkOutput("table drained", outValid0, 0);

      // Counters after the table: ch1 two overflows, ch2 one, ch5 only carry-outs
      readCounter(5'd1, "cnt ch1", 16'd2);
      readCounter(5'd2, "cnt ch2", 16'd1);
      readCounter(5'd5, "cnt ch5 carry", 16'd0);

      // T4: stream 8 samples with OUT_READY low in cycles 3..6
      sent = 0; recv = 0; doneCycle = -1; readyLow = 0;
      stallPrev = 1'b0; heldDql = '0;
      for (int c = 0; c < 40 && recv < 8; c++) begin
         outReady = !(c >= 3 && c <= 6);
         if (sent < 8) applyStimulus(1'b1, vecs[sent].dqln, vecs[sent].y, vecs[sent].ch);
         else          applyStimulus(1'b0, 12'h0, 13'h0, 5'd0);
         #1;
         if (!inReady0) readyLow++;
         if (stallPrev && outValid0) checkOutput("T4 held DQL", dql0, heldDql);
         takeOut = outValid0 && outReady;
         takeIn  = inValid && inReady0;
         if (takeOut) begin
            checkOutput($sformatf("T4 out%0d DQL", recv), dql0, vecs[recv].expWrap);
            checkOutput($sformatf("T4 out%0d CH", recv), chOut0, vecs[recv].ch);
            recv++;
            if (recv == 8) doneCycle = c;
         end
         stallPrev = outValid0 && !outReady;
         heldDql   = dql0;
         tick();
         if (takeIn) sent++;
      end
      checkOutput("T4 received count", recv, 8);
      checkOutput("T4 last output cycle", doneCycle, 13);
      checkOutput("T4 IN_READY low cycles", readyLow, 4);
      checkOutput("T4 no duplicate", outValid0, 0);
      outReady = 1'b1;

      // T5: clear, then 5 overflows on ch3 and 2 on ch7
      cntClr = 1'b1;
      tick();
      cntClr = 1'b0;
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b1, 12'h7FF, 13'h0004, (k < 5) ? 5'd3 : 5'd7);
         tick();
      end
      applyStimulus(1'b0, 12'h0, 13'h0, 5'd0);
      repeat (2) tick();
      readCounter(5'd3, "T5 cnt ch3", 16'd5);
      readCounter(5'd7, "T5 cnt ch7", 16'd2);

      // T5: clear on the same edge as an overflow transfer on ch3
      cntSel = 5'd3;
      applyStimulus(1'b1, 12'h7FF, 13'h0004, 5'd3);
      tick();
      applyStimulus(1'b0, 12'h0, 13'h0, 5'd0);
      cntClr = 1'b1;
      tick();
      cntClr = 1'b0;
      checkOutput("T5 transfer OVF", ovf0, 1);
      tick();
      checkOutput("T5 clear wins wrap", cntOut0, 0);
      checkOutput("T5 clear wins sat", cntOut1, 0);
      readCounter(5'd7, "T5 ch7 cleared", 16'd0);

      // T6: async reset with two samples in flight
      cntSel = 5'd4;
      applyStimulus(1'b1, 12'h7FF, 13'h0004, 5'd4);
      tick();
      applyStimulus(1'b1, 12'h100, 13'h0400, 5'd4);
      tick();
      applyStimulus(1'b0, 12'h0, 13'h0, 5'd0);
      tick();
      checkOutput("T6 pre-reset cnt ch4", cntOut0, 1);
      checkOutput("T6 pre-reset OUT_VALID", outValid0, 1);
      resetN = 1'b0;
      #1;
      checkOutput("T6 OUT_VALID async drop", outValid0, 0);
      checkOutput("T6 CNT_OUT in reset", cntOut0, 0);
      checkOutput("T6 IN_READY in reset", inReady0, 1);
      @(negedge clk);
      resetN = 1'b1;
      tick();
      checkOutput("T6 IN_READY after release", inReady0, 1);
      checkOutput("T6 no stale output", outValid0, 0);
      tick();
      checkOutput("T6 cnt ch4 cleared", cntOut0, 0);
      checkOutput("T6 still empty", outValid0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
